// File: rtl/id_exe_stage_pkg.sv
// id_exe_stage_pkg: forwarding selects, ALU opcodes and control bundle shared by the ID/EXE stage.
package id_exe_stage_pkg;
   typedef enum logic [1:0] {
      FORW_SEL_NONE     = 2'b00,
      FORW_SEL_FROM_EXE = 2'b01,
      FORW_SEL_FROM_MEM = 2'b10
   } fwd_sel_e;
   typedef enum logic [3:0] {
      EXE_CMD_NOP = 4'b0000,
      EXE_CMD_MOV = 4'b0001,
      EXE_CMD_ADD = 4'b0010,
      EXE_CMD_ADC = 4'b0011,
      EXE_CMD_SUB = 4'b0100,
      EXE_CMD_SBC = 4'b0101,
      EXE_CMD_AND = 4'b0110,
      EXE_CMD_ORR = 4'b0111,
      EXE_CMD_EOR = 4'b1000,
      EXE_CMD_MVN = 4'b1001
   } exe_cmd_e;
   typedef struct packed {
      logic wb_en;
      logic mem_r_en;
      logic mem_w_en;
      logic s_update;
      logic branch;
   } ctrl_t;
endpackage

// File: rtl/fwd_operand_mux.sv
// fwd_operand_mux: picks the ALU operand from the register file value or a forwarded producer.
module fwd_operand_mux import id_exe_stage_pkg::*; #(
   parameter int DW = 32
) (
   input  logic [1:0]    sel,
   input  logic [DW-1:0] reg_val,
   input  logic [DW-1:0] mem_alu_res,
   input  logic [DW-1:0] wb_value,
   output logic [DW-1:0] operand
);
   always_comb operand = (sel == FORW_SEL_FROM_EXE) ? mem_alu_res :
                         (sel == FORW_SEL_FROM_MEM) ? wb_value : reg_val;
endmodule

// File: rtl/id_exe_stage.sv
// id_exe_stage: ID/EXE pipeline register with operand forwarding, load-use stall and bubble counter.
module id_exe_stage import id_exe_stage_pkg::*; #(
   parameter int DW    = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             hold,
   input  logic             flush,
   input  logic             id_valid,
   input  logic             id_wb_en,
   input  logic             id_mem_r_en,
   input  logic             id_mem_w_en,
   input  logic             id_s_update,
   input  logic             id_branch,
   input  logic [3:0]       id_exe_cmd,
   input  logic [3:0]       id_dst,
   input  logic [3:0]       id_src1,
   input  logic [3:0]       id_src2,
   input  logic [DW-1:0]    id_val_rn,
   input  logic [DW-1:0]    id_val_rm,
   input  logic [DW-1:0]    id_pc,
   input  logic [11:0]      id_shift_op,
   input  logic             id_imm,
   input  logic [23:0]      id_simm24,
   input  logic [1:0]       id_sel_src1,
   input  logic [1:0]       id_sel_src2,
   input  logic [DW-1:0]    mem_alu_res,
   input  logic [DW-1:0]    wb_value,
   output logic             exe_valid,
   output logic             exe_wb_en,
   output logic             exe_mem_r_en,
   output logic             exe_mem_w_en,
   output logic             exe_s_update,
   output logic             exe_branch,
   output logic [3:0]       exe_exe_cmd,
   output logic [3:0]       exe_dst,
   output logic [3:0]       exe_src1,
   output logic [3:0]       exe_src2,
   output logic [DW-1:0]    exe_val_rn,
   output logic [DW-1:0]    exe_val_rm,
   output logic [DW-1:0]    exe_pc,
   output logic [11:0]      exe_shift_op,
   output logic             exe_imm,
   output logic [23:0]      exe_simm24,
   output logic [1:0]       exe_sel_src1,
   output logic [1:0]       exe_sel_src2,
   output logic [DW-1:0]    exe_op1,
   output logic [DW-1:0]    exe_op2,
   output logic             load_use_stall,
   output logic [CNT_W-1:0] bubble_cnt
);
   logic             valid_q, imm_q, bubble;
   ctrl_t            ctrl_q, ctrl_d;
   logic [3:0]       cmd_q, dst_q, src1_q, src2_q;
   logic [DW-1:0]    rn_q, rm_q, pc_q;
   logic [11:0]      shift_op_q;
   logic [23:0]      simm24_q;
   logic [1:0]       sel1_q, sel2_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   // A load in EXE has no result yet, so a dependent ID instruction must wait one cycle.
   assign load_use_stall = valid_q & ctrl_q.mem_r_en & ctrl_q.wb_en
                         & (dst_q == id_src1 | dst_q == id_src2) & id_valid & ~flush;
   assign bubble = flush | (load_use_stall & ~hold);
   assign ctrl_d = id_valid ? ctrl_t'{id_wb_en, id_mem_r_en, id_mem_w_en, id_s_update, id_branch} : '0;
   assign cnt_d  = &cnt_q ? cnt_q : cnt_q + CNT_W'(1);
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q    <= 1'b0;
         ctrl_q     <= '0;
         cmd_q      <= '0;
         dst_q      <= '0;
         src1_q     <= '0;
         src2_q     <= '0;
         rn_q       <= '0;
         rm_q       <= '0;
         pc_q       <= '0;
         shift_op_q <= '0;
         imm_q      <= 1'b0;
         simm24_q   <= '0;
         sel1_q     <= '0;
         sel2_q     <= '0;
         cnt_q      <= '0;
      end else if (bubble) begin
         valid_q <= 1'b0;
         ctrl_q  <= '0;
         cnt_q   <= cnt_d;
      end else if (!hold) begin
         valid_q    <= id_valid;
         ctrl_q     <= ctrl_d;
         cmd_q      <= id_exe_cmd;
         dst_q      <= id_dst;
         src1_q     <= id_src1;
         src2_q     <= id_src2;
         rn_q       <= id_val_rn;
         rm_q       <= id_val_rm;
         pc_q       <= id_pc;
         shift_op_q <= id_shift_op;
         imm_q      <= id_imm;
         simm24_q   <= id_simm24;
         sel1_q     <= id_sel_src1;
         sel2_q     <= id_sel_src2;
      end
   end
   assign exe_valid    = valid_q;
   assign exe_wb_en    = ctrl_q.wb_en;
   assign exe_mem_r_en = ctrl_q.mem_r_en;
   assign exe_mem_w_en = ctrl_q.mem_w_en;
   assign exe_s_update = ctrl_q.s_update;
   assign exe_branch   = ctrl_q.branch;
   assign exe_exe_cmd  = cmd_q;
   assign exe_dst      = dst_q;
   assign exe_src1     = src1_q;
   assign exe_src2     = src2_q;
   assign exe_val_rn   = rn_q;
   assign exe_val_rm   = rm_q;
   assign exe_pc       = pc_q;
   assign exe_shift_op = shift_op_q;
   assign exe_imm      = imm_q;
   assign exe_simm24   = simm24_q;
   assign exe_sel_src1 = sel1_q;
   assign exe_sel_src2 = sel2_q;
   assign bubble_cnt   = cnt_q;
   fwd_operand_mux #(.DW(DW)) u_mux1 (
      .sel(sel1_q), .reg_val(rn_q), .mem_alu_res(mem_alu_res), .wb_value(wb_value), .operand(exe_op1)
   );
   fwd_operand_mux #(.DW(DW)) u_mux2 (
      .sel(sel2_q), .reg_val(rm_q), .mem_alu_res(mem_alu_res), .wb_value(wb_value), .operand(exe_op2)
   );
endmodule
